// File: rtl/reflet_rom_arbiter.sv
// reflet_rom_arbiter: shares one registered-output ROM between two req/ack byte readers
module reflet_rom_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter bit FAIR       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_enable,
  input  logic [DATA_WIDTH-1:0] rom_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
  state_t state, state_nx;
  logic sel, last_grant, gnt;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE    ? ((req0 | req1) ? ISSUE : IDLE) :
               state == ISSUE   ? CAPTURE : IDLE;
  always_comb begin
    busy = state != IDLE;
    gnt  = (req0 & req1) ? (FAIR ? ~last_grant : 1'b0) : req1;
  end
  // Address is latched at grant so requester address changes mid-access are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      rom_addr   <= '0;
      rom_enable <= 1'b0;
      sel        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      ack0       <= state == CAPTURE && !sel;
      ack1       <= state == CAPTURE && sel;
      rom_enable <= state == ISSUE;
      if (state == IDLE && (req0 | req1)) begin
        sel      <= gnt;
        rom_addr <= gnt ? addr1 : addr0;
      end
      if (state == CAPTURE) begin
        last_grant <= sel;
        if (sel) rdata1 <= rom_data;
        else     rdata0 <= rom_data;
      end
    end
  end
endmodule

// File: tb/tb_reflet_rom_arbiter.sv
// tb_reflet_rom_arbiter: directed bench driving a round-robin and a fixed-priority arbiter
module tb_reflet_rom_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [6:0] addr0 = '0, addr1 = '0;
  logic f_ack0, f_ack1, f_busy, f_en, p_ack0, p_ack1, p_busy, p_en;
  logic [7:0] f_rd0, f_rd1, p_rd0, p_rd1, f_dout, p_dout, f_rom, p_rom;
  logic [6:0] f_addr, p_addr;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_img(input logic [6:0] a);
    case (a)
      7'h00: return 8'h41;
      7'h01: return 8'h53;
      7'h02: return 8'h52;
      7'h03: return 8'h4D;
      7'h5A: return 8'h0E;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    f_dout <= rom_img(f_addr);
    p_dout <= rom_img(p_addr);
  end
  assign f_rom = f_en ? f_dout : 8'h00;
  assign p_rom = p_en ? p_dout : 8'h00;

  reflet_rom_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .FAIR(1'b1)) u_fair (
    .clk(clk), .reset(reset), .req0(req0), .addr0(addr0), .ack0(f_ack0), .rdata0(f_rd0),
    .req1(req1), .addr1(addr1), .ack1(f_ack1), .rdata1(f_rd1), .busy(f_busy),
    .rom_addr(f_addr), .rom_enable(f_en), .rom_data(f_rom));

  reflet_rom_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .FAIR(1'b0)) u_prio (
    .clk(clk), .reset(reset), .req0(req0), .addr0(addr0), .ack0(p_ack0), .rdata0(p_rd0),
    .req1(req1), .addr1(addr1), .ack1(p_ack1), .rdata1(p_rd1), .busy(p_busy),
    .rom_addr(p_addr), .rom_enable(p_en), .rom_data(p_rom));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ack0", f_ack0, 0);
    chk("rst_ack1", f_ack1, 0);
    chk("rst_rdata", {f_rd0, f_rd1}, 0);
    chk("rst_rom_addr", f_addr, 0);
    chk("rst_rom_en", f_en, 0);
    chk("rst_busy", {f_busy, p_busy}, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", {f_ack0, f_ack1, f_busy, f_en, f_rd0, f_rd1, f_addr}, 0);
    end
    // single port-0 read
    addr0 = 7'h00; req0 = 1'b1;
    @(negedge clk);
    chk("p0_issue_busy", f_busy, 1);
    chk("p0_issue_ack", f_ack0, 0);
    chk("p0_issue_en", f_en, 0);
    @(negedge clk);
    chk("p0_cap_en", f_en, 1);
    chk("p0_cap_ack", f_ack0, 0);
    @(negedge clk);
    chk("p0_ack0", f_ack0, 1);
    chk("p0_ack1", f_ack1, 0);
    chk("p0_rdata0", f_rd0, 8'h41);
    req0 = 1'b0;
    @(negedge clk);
    chk("p0_ack_pulse", f_ack0, 0);
    chk("p0_rdata_hold", f_rd0, 8'h41);
    chk("p0_idle", {f_busy, f_en}, 0);
    // both ports held: fair alternates, priority starves port 1 until req0 drops
    rst_pulse();
    addr0 = 7'h01; addr1 = 7'h5A; req0 = 1'b1; req1 = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk($sformatf("fair_acks_k%0d", k), {f_ack0, f_ack1},
          {k == 3 || k == 9, k == 6 || k == 12 || k == 15});
      chk($sformatf("prio_acks_k%0d", k), {p_ack0, p_ack1},
          {k % 3 == 0 && k <= 12, k == 15});
      chk($sformatf("busy_k%0d", k), {f_busy, p_busy}, {2{k % 3 != 0}});
      if (k == 12) req0 = 1'b0;
      if (k == 15) req1 = 1'b0;
    end
    chk("fair_rdata0", f_rd0, 8'h53);
    chk("fair_rdata1", f_rd1, 8'h0E);
    chk("prio_rdata0", p_rd0, 8'h53);
    chk("prio_rdata1", p_rd1, 8'h0E);
    // address latched at grant; req dropped during ISSUE still completes
    rst_pulse();
    addr1 = 7'h03; req1 = 1'b1;
    @(negedge clk);
    chk("lat_busy", f_busy, 1);
    addr1 = 7'h02; req1 = 1'b0;
    @(negedge clk);
    chk("lat_ack_early", f_ack1, 0);
    chk("lat_rom_addr", f_addr, 7'h03);
    @(negedge clk);
    chk("lat_ack1", f_ack1, 1);
    chk("lat_rdata1", f_rd1, 8'h4D);
    chk("lat_rdata0_untouched", f_rd0, 0);
    @(negedge clk);
    chk("lat_ack_pulse", f_ack1, 0);
    chk("lat_rom_addr_hold", f_addr, 7'h03);
    // reset arriving on the capture edge drops the access
    rst_pulse();
    addr0 = 7'h02; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    chk("rc_cap_en", f_en, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rc_ack0", f_ack0, 0);
    chk("rc_rdata0", f_rd0, 0);
    chk("rc_idle", {f_busy, f_en}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rc_no_late_ack", {f_ack0, f_ack1}, 0);
    addr0 = 7'h7F; req0 = 1'b1;
    repeat (2) @(negedge clk);
    chk("hi_ack_early", f_ack0, 0);
    @(negedge clk);
    chk("hi_ack0", f_ack0, 1);
    chk("hi_rdata0", f_rd0, 0);
    chk("hi_rom_addr", f_addr, 7'h7F);
    req0 = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
